fighter_hit_resolver: RTL and testbench
=======================================

// Module: fighter_hit_resolver
// PURPOSE
//  Two-player hit/hurt box engine. It generates frame-stable boxes for both fighters from their
//  FSM state, position and facing, and detects hitbox-vs-hurtbox overlap once per frame.
//  It emits one-shot hit pulses and runs a hitstop freeze. Sits between the two fighter FSMs
//  and the game/score logic; all box outputs feed the renderer.
// PARAMETERS
//  SPRITE_W        64   sprite width, px
//  SPRITE_H        128  sprite height, px
//  HURT_MARGIN     10   hurtbox inset from each sprite side, px
//  HIT_W           30   hitbox width, px
//  HIT_H           60   hitbox height, px; vertically centred in the sprite
//  COORD_MAX       639  saturation limit for every box edge
//  HITSTOP_FRAMES  8    frames frozen after a hit; 0 = no hitstop
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  frame_tick      in   1    1-cycle pulse, once per video frame
//  p1_state        in   3    P1 FSM state (IDLE..ATTACK_RECOVERY encoding, 0..5)
//  p2_state        in   3    P2 FSM state
//  p1_x, p1_y      in   10   P1 sprite top-left
//  p2_x, p2_y      in   10   P2 sprite top-left
//  p1_face_left    in   1    1 = P1 hitbox extends left of the sprite
//  p2_face_left    in   1    1 = P2 hitbox extends left of the sprite
//  pN_hit_{x1,x2,y1,y2}  out 10 each  registered hitbox, N=1,2 (zero when inactive)
//  pN_hurt_{x1,x2,y1,y2} out 10 each  registered hurtbox, N=1,2
//  pN_hit_active   out  1    hitbox valid, N=1,2
//  p1_scores       out  1    1-cycle pulse: P1 hitbox struck P2 hurtbox
//  p2_scores       out  1    1-cycle pulse: P2 hitbox struck P1 hurtbox
//  freeze          out  1    hitstop in progress; fighters must hold state
// BEHAVIOUR
//  Reset: all box outputs 0, hit_active 0, pulses 0, freeze 0, hit latches 0, FSM IDLE.
//  FSM IDLE -> SNAP on frame_tick; SNAP -> CHECK; CHECK -> HITSTOP if a hit fired and
//   HITSTOP_FRAMES>0, else IDLE; HITSTOP -> IDLE on the HITSTOP_FRAMES-th frame_tick.
//  Latency: boxes update at T+1 after frame_tick at T; scores pulse at T+2. Boxes hold between ticks.
//  Hurtbox: x1=x+HURT_MARGIN, x2=x+SPRITE_W-HURT_MARGIN, y1=y, y2=y+SPRITE_H.
//  Hitbox only when state==ATTACK_ACTIVE (4). Facing right: x1=x+SPRITE_W, x2=x1+HIT_W.
//   Facing left: x2=x, x1=x-HIT_W. y1=y+(SPRITE_H-HIT_H)/2, y2=y1+HIT_H.
//  Arithmetic in 11 bits. Edges saturate to [0, COORD_MAX]; no wrap-around.
//  Overlap strict: a.x1<b.x2 && b.x1<a.x2 && a.y1<b.y2 && b.y1<a.y2. Touching edges = no hit.
//  Inactive hitbox never overlaps.
//  Hit latch per attacker: set when its score pulse fires. Further scores are blocked while set.
//   Cleared at SNAP when that player's state != 4. One hit per attack.
//  Both overlap in the same CHECK (trade): both pulses fire, both latches set, one hitstop.
//  freeze rises with the score pulse and falls in the cycle after the last counted frame_tick.
//  In HITSTOP, boxes and latches hold and no CHECK runs; frame_tick only decrements the counter.
//  frame_tick during SNAP/CHECK is ignored.
//  rst mid-hitstop: immediate return to reset values, freeze 0 next cycle.
// CONFIGURATION
//  BOX_OVERLAY_EN defined: adds ports pix_x(in,10), pix_y(in,10), ovl_hit(out,1), ovl_hurt(out,1).
//   Outputs are registered with 1-cycle latency. ovl_hit = pixel inside any active hitbox
//   (inclusive edges). ovl_hurt = pixel inside any hurtbox. Reset value 0.
//  BOX_OVERLAY_EN undefined: those ports and logic are absent. All other behaviour is identical.
// STRUCTURE
//  Shared include fighter_defs.vh holds the state encodings (S_IDLE..S_ATTACK_RECOVERY) and the
//  sprite/box default constants used by the fighter FSMs and the renderer.
//  Sub-module fighter_box_gen is combinational, one instance per player, with saturating edge
//  maths and facing mirror. Registers, overlap test, latches, FSM and hitstop counter live here.
// TESTING
//  1 P1(100,200,right,state4), P2(160,200,idle), tick -> p1_hit x164..194 y234..294;
//    p1_scores pulse at T+2; freeze 8 frames.
//  2 Same with P2 x=184 (hurt x1=194) -> no pulse (touching edge).
//  3 P1 holds state 4 for 5 ticks overlapping -> exactly one p1_scores.
//    State->5->4 then gives a second pulse.
//  4 Both state 4, facing each other, P1 x=100, P2 x=150 -> p1_scores and p2_scores in the
//    same cycle, one hitstop.
//  5 P1 x=620 facing right, state4 -> hit_x1=639, hit_x2=639 (saturated).
//    x=10 facing left -> hit_x1=0.
//  6 rst asserted during hitstop frame 3 -> next cycle all outputs 0, freeze 0.
//    First tick after release -> boxes only, no stale score pulse.

Source files
------------

// File: rtl/fighter_hit_resolver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fighter_hit_resolver_pkg                                                   |
// | Shared fighter state encodings, box geometry defaults, types and helpers.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fighter_hit_resolver_pkg;

  localparam logic [2:0] S_IDLE            = 3'd0;
  localparam logic [2:0] S_WALK            = 3'd1;
  localparam logic [2:0] S_CROUCH          = 3'd2;
  localparam logic [2:0] S_ATTACK_STARTUP  = 3'd3;
  localparam logic [2:0] S_ATTACK_ACTIVE   = 3'd4;
  localparam logic [2:0] S_ATTACK_RECOVERY = 3'd5;

  localparam int c_sprite_w       = 64;
  localparam int c_sprite_h       = 128;
  localparam int c_hurt_margin    = 10;
  localparam int c_hit_w          = 30;
  localparam int c_hit_h          = 60;
  localparam int c_coord_max      = 639;
  localparam int c_hitstop_frames = 8;

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SNAP    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_HITSTOP = 2'd3
  } res_state_e;

  // Clamp a signed edge coordinate into [0, lim].
  function automatic logic [9:0] sat_edge(input logic signed [12:0] v, input logic [9:0] lim);
    logic [9:0] r;
    if (v < 13'sd0)
      r = '0;
    else if (v > $signed({3'b000, lim}))
      r = lim;
    else
      r = v[9:0];
    return r;
  endfunction

  function automatic logic boxes_overlap(input box_t a, input box_t b);
    return (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_hit_resolver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fighter_hit_resolver_if                                                    |
// | Fighter inputs and box/score outputs of the hit resolver.                  |
// | Optional overlay signals present when BOX_OVERLAY_EN is defined.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fighter_hit_resolver_if;
  logic       frame_tick;
  logic [2:0] p1_state;
  logic [2:0] p2_state;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic       p1_face_left, p2_face_left;
  logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic       p1_hit_active, p2_hit_active;
  logic       p1_scores, p2_scores;
  logic       freeze;
`ifdef BOX_OVERLAY_EN
  logic [9:0] pix_x, pix_y;
  logic       ovl_hit, ovl_hurt;
`endif

  modport master (
    output frame_tick, p1_state, p2_state, p1_x, p1_y, p2_x, p2_y,
           p1_face_left, p2_face_left,
`ifdef BOX_OVERLAY_EN
    output pix_x, pix_y,
    input  ovl_hit, ovl_hurt,
`endif
    input  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
           p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
           p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
           p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
           p1_hit_active, p2_hit_active, p1_scores, p2_scores, freeze
  );

  modport slave (
    input  frame_tick, p1_state, p2_state, p1_x, p1_y, p2_x, p2_y,
           p1_face_left, p2_face_left,
`ifdef BOX_OVERLAY_EN
    input  pix_x, pix_y,
    output ovl_hit, ovl_hurt,
`endif
    output p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
           p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
           p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
           p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
           p1_hit_active, p2_hit_active, p1_scores, p2_scores, freeze
  );
endinterface
`default_nettype wire

// File: rtl/fighter_hit_resolver_box_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fighter_box_gen                                                            |
// | Combinational hit/hurt box generator for one fighter, saturating edges.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fighter_box_gen
  import fighter_hit_resolver_pkg::*;
#(
  parameter int SPRITE_W    = c_sprite_w,
  parameter int SPRITE_H    = c_sprite_h,
  parameter int HURT_MARGIN = c_hurt_margin,
  parameter int HIT_W       = c_hit_w,
  parameter int HIT_H       = c_hit_h,
  parameter int COORD_MAX   = c_coord_max
) (
  input  wire logic [2:0] i_state,
  input  wire logic [9:0] i_x,
  input  wire logic [9:0] i_y,
  input  wire logic       i_face_left,
  output box_t            o_hit_box,
  output box_t            o_hurt_box,
  output logic            o_hit_active
);

  localparam logic signed [12:0] c_sw   = 13'(SPRITE_W);
  localparam logic signed [12:0] c_sh   = 13'(SPRITE_H);
  localparam logic signed [12:0] c_hm   = 13'(HURT_MARGIN);
  localparam logic signed [12:0] c_hw   = 13'(HIT_W);
  localparam logic signed [12:0] c_hh   = 13'(HIT_H);
  localparam logic signed [12:0] c_voff = 13'((SPRITE_H - HIT_H) / 2);
  localparam logic [9:0]         c_lim  = 10'(COORD_MAX);

  logic signed [12:0] w_x, w_y, w_hx1, w_hx2, w_hy1, w_hy2;
  logic               w_active;

  always_comb begin
    w_x      = $signed({3'b000, i_x});
    w_y      = $signed({3'b000, i_y});
    w_active = (i_state == S_ATTACK_ACTIVE);
    // Raw edges are kept wide and signed so the mirror to the left can go negative before clamping.
    w_hx1    = i_face_left ? (w_x - c_hw) : (w_x + c_sw);
    w_hx2    = w_hx1 + c_hw;
    w_hy1    = w_y + c_voff;
    w_hy2    = w_hy1 + c_hh;

    o_hurt_box.x1 = sat_edge(w_x + c_hm, c_lim);
    o_hurt_box.x2 = sat_edge(w_x + c_sw - c_hm, c_lim);
    o_hurt_box.y1 = sat_edge(w_y, c_lim);
    o_hurt_box.y2 = sat_edge(w_y + c_sh, c_lim);

    o_hit_box = '0;
    if (w_active) begin
      o_hit_box.x1 = sat_edge(w_hx1, c_lim);
      o_hit_box.x2 = sat_edge(w_hx2, c_lim);
      o_hit_box.y1 = sat_edge(w_hy1, c_lim);
      o_hit_box.y2 = sat_edge(w_hy2, c_lim);
    end
    o_hit_active = w_active;
  end

endmodule
`default_nettype wire

// File: rtl/fighter_hit_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fighter_hit_resolver                                                       |
// | Two-player box snapshot, strict overlap test, one-hit-per-attack latches   |
// | and hitstop freeze. Optional pixel overlay enabled by BOX_OVERLAY_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fighter_hit_resolver
  import fighter_hit_resolver_pkg::*;
#(
  parameter int SPRITE_W       = c_sprite_w,
  parameter int SPRITE_H       = c_sprite_h,
  parameter int HURT_MARGIN    = c_hurt_margin,
  parameter int HIT_W          = c_hit_w,
  parameter int HIT_H          = c_hit_h,
  parameter int COORD_MAX      = c_coord_max,
  parameter int HITSTOP_FRAMES = c_hitstop_frames
) (
  input wire logic              clk,
  input wire logic              rst,
  fighter_hit_resolver_if.slave bus
);

  localparam int              c_cnt_w   = (HITSTOP_FRAMES > 1) ? $clog2(HITSTOP_FRAMES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(HITSTOP_FRAMES);

  box_t w_p1_hit, w_p1_hurt, w_p2_hit, w_p2_hurt;
  logic w_p1_act, w_p2_act;
  box_t r_p1_hit, r_p1_hurt, r_p2_hit, r_p2_hurt;
  logic r_p1_act, r_p2_act;
  logic r_p1_latch, r_p2_latch;
  logic r_p1_scores, r_p2_scores, r_freeze;
  logic [c_cnt_w-1:0] r_hs_cnt;

  res_state_e r_state, w_next;
  logic w_capture, w_resolve, w_load_cnt, w_dec_cnt, w_hs_end;
  logic w_p1_fire, w_p2_fire;

  fighter_box_gen #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .HURT_MARGIN(HURT_MARGIN),
    .HIT_W(HIT_W), .HIT_H(HIT_H), .COORD_MAX(COORD_MAX)
  ) u_box_p1 (
    .i_state(bus.p1_state), .i_x(bus.p1_x), .i_y(bus.p1_y), .i_face_left(bus.p1_face_left),
    .o_hit_box(w_p1_hit), .o_hurt_box(w_p1_hurt), .o_hit_active(w_p1_act)
  );

  fighter_box_gen #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .HURT_MARGIN(HURT_MARGIN),
    .HIT_W(HIT_W), .HIT_H(HIT_H), .COORD_MAX(COORD_MAX)
  ) u_box_p2 (
    .i_state(bus.p2_state), .i_x(bus.p2_x), .i_y(bus.p2_y), .i_face_left(bus.p2_face_left),
    .o_hit_box(w_p2_hit), .o_hurt_box(w_p2_hurt), .o_hit_active(w_p2_act)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_resolve  = 1'b0;
    w_load_cnt = 1'b0;
    w_dec_cnt  = 1'b0;
    w_hs_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_tick) begin
          w_next    = ST_SNAP;
          w_capture = 1'b1;
        end
      end
      ST_SNAP: begin
        w_next    = ST_CHECK;
        w_resolve = 1'b1;
      end
      ST_CHECK: begin
        if ((r_p1_scores || r_p2_scores) && (HITSTOP_FRAMES > 0)) begin
          w_next     = ST_HITSTOP;
          w_load_cnt = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_HITSTOP: begin
        if (bus.frame_tick) begin
          if (r_hs_cnt <= c_cnt_one) begin
            w_next   = ST_IDLE;
            w_hs_end = 1'b1;
          end else begin
            w_dec_cnt = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // An attacker whose latch is still set from the current attack cannot score again.
  assign w_p1_fire = r_p1_act && !r_p1_latch && boxes_overlap(r_p1_hit, r_p2_hurt);
  assign w_p2_fire = r_p2_act && !r_p2_latch && boxes_overlap(r_p2_hit, r_p1_hurt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_hit    <= '0;
      r_p1_hurt   <= '0;
      r_p2_hit    <= '0;
      r_p2_hurt   <= '0;
      r_p1_act    <= 1'b0;
      r_p2_act    <= 1'b0;
      r_p1_latch  <= 1'b0;
      r_p2_latch  <= 1'b0;
      r_p1_scores <= 1'b0;
      r_p2_scores <= 1'b0;
      r_freeze    <= 1'b0;
      r_hs_cnt    <= '0;
    end else begin
      r_p1_scores <= 1'b0;
      r_p2_scores <= 1'b0;
      if (w_capture) begin
        r_p1_hit  <= w_p1_hit;
        r_p1_hurt <= w_p1_hurt;
        r_p2_hit  <= w_p2_hit;
        r_p2_hurt <= w_p2_hurt;
        r_p1_act  <= w_p1_act;
        r_p2_act  <= w_p2_act;
      end
      if (w_resolve) begin
        r_p1_scores <= w_p1_fire;
        r_p2_scores <= w_p2_fire;
        r_p1_latch  <= (r_p1_latch && r_p1_act) || w_p1_fire;
        r_p2_latch  <= (r_p2_latch && r_p2_act) || w_p2_fire;
        r_freeze    <= (w_p1_fire || w_p2_fire) && (HITSTOP_FRAMES > 0);
      end
      if (w_load_cnt)
        r_hs_cnt <= c_cnt_load;
      else if (w_dec_cnt)
        r_hs_cnt <= r_hs_cnt - c_cnt_one;
      if (w_hs_end)
        r_freeze <= 1'b0;
    end
  end

  assign bus.p1_hit_x1     = r_p1_hit.x1;
  assign bus.p1_hit_x2     = r_p1_hit.x2;
  assign bus.p1_hit_y1     = r_p1_hit.y1;
  assign bus.p1_hit_y2     = r_p1_hit.y2;
  assign bus.p2_hit_x1     = r_p2_hit.x1;
  assign bus.p2_hit_x2     = r_p2_hit.x2;
  assign bus.p2_hit_y1     = r_p2_hit.y1;
  assign bus.p2_hit_y2     = r_p2_hit.y2;
  assign bus.p1_hurt_x1    = r_p1_hurt.x1;
  assign bus.p1_hurt_x2    = r_p1_hurt.x2;
  assign bus.p1_hurt_y1    = r_p1_hurt.y1;
  assign bus.p1_hurt_y2    = r_p1_hurt.y2;
  assign bus.p2_hurt_x1    = r_p2_hurt.x1;
  assign bus.p2_hurt_x2    = r_p2_hurt.x2;
  assign bus.p2_hurt_y1    = r_p2_hurt.y1;
  assign bus.p2_hurt_y2    = r_p2_hurt.y2;
  assign bus.p1_hit_active = r_p1_act;
  assign bus.p2_hit_active = r_p2_act;
  assign bus.p1_scores     = r_p1_scores;
  assign bus.p2_scores     = r_p2_scores;
  assign bus.freeze        = r_freeze;

`ifdef BOX_OVERLAY_EN
  logic r_ovl_hit, r_ovl_hurt;

  function automatic logic pix_in(input box_t b, input logic [9:0] px, input logic [9:0] py);
    return (px >= b.x1) && (px <= b.x2) && (py >= b.y1) && (py <= b.y2);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovl_hit  <= 1'b0;
      r_ovl_hurt <= 1'b0;
    end else begin
      r_ovl_hit  <= (r_p1_act && pix_in(r_p1_hit, bus.pix_x, bus.pix_y)) ||
                    (r_p2_act && pix_in(r_p2_hit, bus.pix_x, bus.pix_y));
      r_ovl_hurt <= pix_in(r_p1_hurt, bus.pix_x, bus.pix_y) ||
                    pix_in(r_p2_hurt, bus.pix_x, bus.pix_y);
    end
  end

  assign bus.ovl_hit  = r_ovl_hit;
  assign bus.ovl_hurt = r_ovl_hurt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fighter_hit_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fighter_hit_resolver                                                    |
// | Directed and randomized frames against a frame-level box/score model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fighter_hit_resolver;

  typedef struct {
    int x1;
    int x2;
    int y1;
    int y2;
  } mbox_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Model: [0]=p1 hit, [1]=p1 hurt, [2]=p2 hit, [3]=p2 hurt
  mbox_t m_box [4];
  bit    m_act [2];
  bit    m_latch [2];
  int    m_hs;

  fighter_hit_resolver_if bus ();

  fighter_hit_resolver dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int clampc(int v);
    return (v < 0) ? 0 : ((v > 639) ? 639 : v);
  endfunction

  function automatic mbox_t hurt_of(int x, int y);
    mbox_t r;
    r.x1 = clampc(x + 10);
    r.x2 = clampc(x + 54);
    r.y1 = clampc(y);
    r.y2 = clampc(y + 128);
    return r;
  endfunction

  function automatic mbox_t hit_of(int st, int x, int y, int f);
    mbox_t r;
    r = '{0, 0, 0, 0};
    if (st == 4) begin
      r.x1 = f ? clampc(x - 30) : clampc(x + 64);
      r.x2 = f ? clampc(x) : clampc(x + 94);
      r.y1 = clampc(y + 34);
      r.y2 = clampc(y + 94);
    end
    return r;
  endfunction

  function automatic bit ovl(mbox_t a, mbox_t b);
    return (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_boxes(input string tag);
    chk({tag, ".p1_hit_x1"},  bus.p1_hit_x1,  m_box[0].x1);
    chk({tag, ".p1_hit_x2"},  bus.p1_hit_x2,  m_box[0].x2);
    chk({tag, ".p1_hit_y1"},  bus.p1_hit_y1,  m_box[0].y1);
    chk({tag, ".p1_hit_y2"},  bus.p1_hit_y2,  m_box[0].y2);
    chk({tag, ".p1_hurt_x1"}, bus.p1_hurt_x1, m_box[1].x1);
    chk({tag, ".p1_hurt_x2"}, bus.p1_hurt_x2, m_box[1].x2);
    chk({tag, ".p1_hurt_y1"}, bus.p1_hurt_y1, m_box[1].y1);
    chk({tag, ".p1_hurt_y2"}, bus.p1_hurt_y2, m_box[1].y2);
    chk({tag, ".p2_hit_x1"},  bus.p2_hit_x1,  m_box[2].x1);
    chk({tag, ".p2_hit_x2"},  bus.p2_hit_x2,  m_box[2].x2);
    chk({tag, ".p2_hit_y1"},  bus.p2_hit_y1,  m_box[2].y1);
    chk({tag, ".p2_hit_y2"},  bus.p2_hit_y2,  m_box[2].y2);
    chk({tag, ".p2_hurt_x1"}, bus.p2_hurt_x1, m_box[3].x1);
    chk({tag, ".p2_hurt_x2"}, bus.p2_hurt_x2, m_box[3].x2);
    chk({tag, ".p2_hurt_y1"}, bus.p2_hurt_y1, m_box[3].y1);
    chk({tag, ".p2_hurt_y2"}, bus.p2_hurt_y2, m_box[3].y2);
    chk({tag, ".p1_active"},  bus.p1_hit_active, 32'(m_act[0]));
    chk({tag, ".p2_active"},  bus.p2_hit_active, 32'(m_act[1]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_box[i] = '{0, 0, 0, 0};
    m_act[0] = 0; m_act[1] = 0;
    m_latch[0] = 0; m_latch[1] = 0;
    m_hs = 0;
  endtask

  // One frame_tick with the given fighter inputs, checked through T+3.
  task automatic frame(input int s1, input int x1, input int y1, input int f1,
                       input int s2, input int x2, input int y2, input int f2);
    bit fire1, fire2;
    @(negedge clk);
    bus.p1_state = 3'(s1); bus.p1_x = 10'(x1); bus.p1_y = 10'(y1); bus.p1_face_left = f1[0];
    bus.p2_state = 3'(s2); bus.p2_x = 10'(x2); bus.p2_y = 10'(y2); bus.p2_face_left = f2[0];
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    if (m_hs > 0) begin
      m_hs--;
      chk_boxes("hold");
      chk("hold_freeze", bus.freeze, 32'(m_hs > 0));
      chk("hold_p1_scores", bus.p1_scores, 32'd0);
      @(negedge clk);
      chk("hold_p1_scores_b", bus.p1_scores, 32'd0);
      chk("hold_p2_scores_b", bus.p2_scores, 32'd0);
    end else begin
      m_box[0] = hit_of(s1, x1, y1, f1);
      m_box[1] = hurt_of(x1, y1);
      m_box[2] = hit_of(s2, x2, y2, f2);
      m_box[3] = hurt_of(x2, y2);
      m_act[0] = (s1 == 4);
      m_act[1] = (s2 == 4);
      chk_boxes("snap");
      chk("snap_p1_scores", bus.p1_scores, 32'd0);
      chk("snap_p2_scores", bus.p2_scores, 32'd0);
      @(negedge clk);
      if (!m_act[0]) m_latch[0] = 0;
      if (!m_act[1]) m_latch[1] = 0;
      fire1 = m_act[0] && !m_latch[0] && ovl(m_box[0], m_box[3]);
      fire2 = m_act[1] && !m_latch[1] && ovl(m_box[2], m_box[1]);
      if (fire1) m_latch[0] = 1;
      if (fire2) m_latch[1] = 1;
      chk("p1_scores", bus.p1_scores, 32'(fire1));
      chk("p2_scores", bus.p2_scores, 32'(fire2));
      chk("freeze_rise", bus.freeze, 32'(fire1 || fire2));
      if (fire1 || fire2) m_hs = 8;
      @(negedge clk);
      chk("p1_scores_oneshot", bus.p1_scores, 32'd0);
      chk("p2_scores_oneshot", bus.p2_scores, 32'd0);
      chk("freeze_after", bus.freeze, 32'(m_hs > 0));
    end
  endtask

  int px, py, qx, qy;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.frame_tick = 1'b0;
    bus.p1_state = 3'd0; bus.p2_state = 3'd0;
    bus.p1_x = '0; bus.p1_y = '0; bus.p2_x = '0; bus.p2_y = '0;
    bus.p1_face_left = 1'b0; bus.p2_face_left = 1'b0;
`ifdef BOX_OVERLAY_EN
    bus.pix_x = '0; bus.pix_y = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    chk_boxes("reset");
    chk("reset_freeze", bus.freeze, 32'd0);
    chk("reset_p1_scores", bus.p1_scores, 32'd0);
    chk("reset_p2_scores", bus.p2_scores, 32'd0);
    rst = 1'b0;

    // Basic hit, then 8 frozen frames with inputs still changing
    frame(4, 100, 200, 0, 0, 160, 200, 0);
    chk("t1_hit_x1", bus.p1_hit_x1, 32'd164);
    chk("t1_hit_x2", bus.p1_hit_x2, 32'd194);
    chk("t1_hit_y1", bus.p1_hit_y1, 32'd234);
    chk("t1_hit_y2", bus.p1_hit_y2, 32'd294);
    chk("t1_m_hs", 32'(m_hs), 32'd8);
    for (int i = 0; i < 8; i++) frame(4, 100 + i, 200, 0, 0, 160, 200, 0);
    chk("t1_freeze_end", bus.freeze, 32'd0);

    // Held attack scores only once; recovery then a new attack scores again
    for (int i = 0; i < 4; i++) frame(4, 100, 200, 0, 0, 160, 200, 0);
    frame(5, 100, 200, 0, 0, 160, 200, 0);
    frame(4, 100, 200, 0, 0, 160, 200, 0);
    for (int i = 0; i < 8; i++) frame(4, 100, 200, 0, 0, 160, 200, 0);

    // Touching edges
    frame(5, 100, 200, 0, 0, 184, 200, 0);
    frame(4, 100, 200, 0, 0, 184, 200, 0);
    chk("t2_p2_hurt_x1", bus.p2_hurt_x1, 32'd194);
    chk("t2_m_hs", 32'(m_hs), 32'd0);

    // Trade: both score in the same frame, one hitstop
    frame(4, 100, 200, 0, 4, 150, 200, 1);
    chk("t4_m_hs", 32'(m_hs), 32'd8);
    for (int i = 0; i < 8; i++) frame(4, 100, 200, 0, 4, 150, 200, 1);
    chk("t4_freeze_end", bus.freeze, 32'd0);

    // Saturation
    frame(4, 620, 100, 0, 0, 0, 400, 0);
    chk("t5_hit_x1", bus.p1_hit_x1, 32'd639);
    chk("t5_hit_x2", bus.p1_hit_x2, 32'd639);
    frame(4, 10, 100, 1, 0, 400, 400, 0);
    chk("t5_left_x1", bus.p1_hit_x1, 32'd0);
    chk("t5_left_x2", bus.p1_hit_x2, 32'd10);

    // Reset during hitstop
    frame(0, 100, 200, 0, 0, 160, 200, 0);
    frame(4, 100, 200, 0, 0, 160, 200, 0);
    for (int i = 0; i < 3; i++) frame(4, 100, 200, 0, 0, 160, 200, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk_boxes("t6_rst");
    chk("t6_freeze", bus.freeze, 32'd0);
    chk("t6_p1_scores", bus.p1_scores, 32'd0);
    rst = 1'b0;
    frame(0, 100, 200, 0, 0, 160, 200, 0);

    // Randomized close-range frames
    for (int n = 0; n < 80; n++) begin
      px = $urandom_range(0, 700);
      py = $urandom_range(0, 500);
      qx = px + $urandom_range(0, 160) - 80;
      qy = py + $urandom_range(0, 120) - 60;
      if (qx < 0) qx = 0;
      if (qy < 0) qy = 0;
      frame(($urandom_range(0, 7) >= 5) ? 4 : $urandom_range(0, 5), px, py, $urandom_range(0, 1),
            ($urandom_range(0, 7) >= 5) ? 4 : $urandom_range(0, 5), qx, qy, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
